// File: rtl/flag_int_ctrl.sv
// Flag/interrupt sequencer: decodes flag opcodes into C/Z register strobes, owns IE, the shadow C/Z and interrupt entry.
// Latency: strobes and load data are combinational (the flag register updates on the EXEC_STB edge); IE/INT_ACK/STALL are registered.
// Backpressure: STALL holds fetch for 1 SAVE cycle plus ACK_CYCLES ACK cycles; EXEC_STB during that window is ignored.
module flag_int_ctrl #(
    parameter int ACK_CYCLES = 1,
    parameter bit CLR_ON_INT = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EXEC_STB,
    input  logic [2:0] FLG_OP,
    input  logic       INTR,
    input  logic       C_ALU,
    input  logic       Z_ALU,
    input  logic       C_FLG,
    input  logic       Z_FLG,
    output logic       C_SET_FLG,
    output logic       C_CLR_FLG,
    output logic       C_LD_FLG,
    output logic       Z_LD_FLG,
    output logic       C_IN,
    output logic       Z_IN,
    output logic       IE_FLG,
    output logic       INT_ACK,
    output logic       STALL
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_LD_C  = 3'd1;
    localparam logic [2:0] OP_LD_CZ = 3'd2;
    localparam logic [2:0] OP_SET_C = 3'd3;
    localparam logic [2:0] OP_CLR_C = 3'd4;
    localparam logic [2:0] OP_SEI   = 3'd5;
    localparam logic [2:0] OP_CLI   = 3'd6;
    localparam logic [2:0] OP_RETIE = 3'd7;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SAVE = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t     state;
    logic       ie;
    logic       pend;
    logic       shadow_c;
    logic       shadow_z;
    logic [3:0] ack_cnt;
    logic       int_ack_q;
    logic       stall_q;

    logic       ie_next;
    logic       take_int;

    // IE value as it will stand after the current instruction, and the entry decision that uses it
    always_comb begin
        ie_next = ie;
        if (state == RUN && EXEC_STB) begin
            case (FLG_OP)
                OP_SEI, OP_RETIE: ie_next = 1'b1;
                OP_CLI:           ie_next = 1'b0;
                default:          ie_next = ie;
            endcase
        end
        take_int = (state == RUN) && EXEC_STB && ie_next && (pend || INTR);
    end

    // Flag register strobes and load-data mux; everything quiet while in reset
    always_comb begin
        C_SET_FLG = 1'b0;
        C_CLR_FLG = 1'b0;
        C_LD_FLG  = 1'b0;
        Z_LD_FLG  = 1'b0;
        C_IN      = C_ALU;
        Z_IN      = Z_ALU;
        if (!RST) begin
            case (state)
                RUN: begin
                    if (EXEC_STB) begin
                        case (FLG_OP)
                            OP_LD_C:  C_LD_FLG = 1'b1;
                            OP_LD_CZ: begin
                                C_LD_FLG = 1'b1;
                                Z_LD_FLG = 1'b1;
                            end
                            OP_SET_C: C_SET_FLG = 1'b1;
                            OP_CLR_C: C_CLR_FLG = 1'b1;
                            OP_RETIE: begin
                                C_LD_FLG = 1'b1;
                                Z_LD_FLG = 1'b1;
                                C_IN     = shadow_c;
                                Z_IN     = shadow_z;
                            end
                            default: ;
                        endcase
                    end
                end
                SAVE: begin
                    // C uses its clear strobe, Z has none so it is loaded with 0
                    if (CLR_ON_INT) begin
                        C_CLR_FLG = 1'b1;
                        Z_LD_FLG  = 1'b1;
                        Z_IN      = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer: RUN -> SAVE (1 cycle) -> ACK (ACK_CYCLES cycles) -> RUN, with registered INT_ACK/STALL
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            ie        <= 1'b0;
            pend      <= 1'b0;
            shadow_c  <= 1'b0;
            shadow_z  <= 1'b0;
            ack_cnt   <= 4'd0;
            int_ack_q <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            // A request is latched until the entry it triggers is actually taken
            pend <= take_int ? 1'b0 : (pend | INTR);
            case (state)
                RUN: begin
                    ie <= ie_next;
                    if (take_int) begin
                        state   <= SAVE;
                        stall_q <= 1'b1;
                    end
                end
                SAVE: begin
                    shadow_c  <= C_FLG;
                    shadow_z  <= Z_FLG;
                    ie        <= 1'b0;
                    ack_cnt   <= 4'(ACK_CYCLES - 1);
                    state     <= ACK;
                    int_ack_q <= 1'b1;
                    stall_q   <= 1'b1;
                end
                ACK: begin
                    if (ack_cnt == 4'd0) begin
                        state     <= RUN;
                        int_ack_q <= 1'b0;
                        stall_q   <= 1'b0;
                    end else begin
                        ack_cnt <= ack_cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= RUN;
                    int_ack_q <= 1'b0;
                    stall_q   <= 1'b0;
                end
            endcase
        end
    end

    assign IE_FLG  = ie;
    assign INT_ACK = int_ack_q;
    assign STALL   = stall_q;

endmodule

// File: tb/tb_flag_int_ctrl.sv
// Bench for flag_int_ctrl: two instances (ACK_CYCLES=1/CLR_ON_INT=1 and ACK_CYCLES=3/CLR_ON_INT=0) share stimulus.
// Directed vector table first, then randomized cycles against a reference model.
// Outputs are compared on the falling edge; inputs change 1 time unit after the rising edge.
module tb_flag_int_ctrl;

    logic       clk = 1'b0;
    logic       rst, exec_stb, intr, c_alu, z_alu, c_flg, z_flg;
    logic [2:0] flg_op;

    logic a_cset, a_cclr, a_cld, a_zld, a_cin, a_zin, a_ie, a_ack, a_stall;
    logic b_cset, b_cclr, b_cld, b_zld, b_cin, b_zin, b_ie, b_ack, b_stall;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    flag_int_ctrl #(.ACK_CYCLES(1), .CLR_ON_INT(1'b1)) dut_a (
        .CLK(clk), .RST(rst), .EXEC_STB(exec_stb), .FLG_OP(flg_op), .INTR(intr),
        .C_ALU(c_alu), .Z_ALU(z_alu), .C_FLG(c_flg), .Z_FLG(z_flg),
        .C_SET_FLG(a_cset), .C_CLR_FLG(a_cclr), .C_LD_FLG(a_cld), .Z_LD_FLG(a_zld),
        .C_IN(a_cin), .Z_IN(a_zin), .IE_FLG(a_ie), .INT_ACK(a_ack), .STALL(a_stall)
    );

    flag_int_ctrl #(.ACK_CYCLES(3), .CLR_ON_INT(1'b0)) dut_b (
        .CLK(clk), .RST(rst), .EXEC_STB(exec_stb), .FLG_OP(flg_op), .INTR(intr),
        .C_ALU(c_alu), .Z_ALU(z_alu), .C_FLG(c_flg), .Z_FLG(z_flg),
        .C_SET_FLG(b_cset), .C_CLR_FLG(b_cclr), .C_LD_FLG(b_cld), .Z_LD_FLG(b_zld),
        .C_IN(b_cin), .Z_IN(b_zin), .IE_FLG(b_ie), .INT_ACK(b_ack), .STALL(b_stall)
    );

    // Output vector bit order: {C_SET, C_CLR, C_LD, Z_LD, C_IN, Z_IN, IE, INT_ACK, STALL}
    function automatic logic [8:0] outs(input int k);
        if (k == 0) return {a_cset, a_cclr, a_cld, a_zld, a_cin, a_zin, a_ie, a_ack, a_stall};
        return {b_cset, b_cclr, b_cld, b_zld, b_cin, b_zin, b_ie, b_ack, b_stall};
    endfunction

    task automatic check(input string name, input int idx, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s #%0d: got %b expected %b", name, idx, got, exp);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int         which;  // 0: check dut_a, 1: check dut_b, 2: drive only
        logic       rst, exec_stb;
        logic [2:0] op;
        logic       intr, ca, za, cf, zf;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int w, input logic r, input logic e, input logic [2:0] o, input logic i,
                       input logic ca, input logic za, input logic cf, input logic zf, input logic [8:0] x);
        vec_t v;
        v.which = w; v.rst = r; v.exec_stb = e; v.op = o; v.intr = i;
        v.ca = ca; v.za = za; v.cf = cf; v.zf = zf; v.exp = x;
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // busy counts remaining stalled cycles: ACK+1 means the save cycle, 1..ACK the acknowledge cycles.
    int   m_ack[2] = '{1, 3};
    bit   m_clr[2] = '{1'b1, 1'b0};
    int   m_busy[2];
    bit   m_ie[2], m_pend[2], m_shc[2], m_shz[2];

    function automatic logic [8:0] model_out(input int k);
        bit cset = 0, cclr = 0, cld = 0, zld = 0, cin = c_alu, zin = z_alu;
        bit in_save = (m_busy[k] == m_ack[k] + 1);
        if (!rst) begin
            if (in_save && m_clr[k]) begin
                cclr = 1; zld = 1; zin = 0;
            end else if (m_busy[k] == 0 && exec_stb) begin
                case (flg_op)
                    3'd1: cld = 1;
                    3'd2: begin cld = 1; zld = 1; end
                    3'd3: cset = 1;
                    3'd4: cclr = 1;
                    3'd7: begin cld = 1; zld = 1; cin = m_shc[k]; zin = m_shz[k]; end
                    default: ;
                endcase
            end
        end
        return {cset, cclr, cld, zld, cin, zin, m_ie[k],
                (m_busy[k] > 0 && m_busy[k] <= m_ack[k]), (m_busy[k] > 0)};
    endfunction

    task automatic model_step(input int k);
        bit req = m_pend[k] | intr;
        bit ie_after;
        if (rst) begin
            m_busy[k] = 0; m_ie[k] = 0; m_pend[k] = 0; m_shc[k] = 0; m_shz[k] = 0;
        end else if (m_busy[k] == 0) begin
            ie_after = m_ie[k];
            if (exec_stb && (flg_op == 3'd5 || flg_op == 3'd7)) ie_after = 1;
            if (exec_stb && flg_op == 3'd6) ie_after = 0;
            m_ie[k] = ie_after;
            if (exec_stb && ie_after && req) begin
                m_busy[k] = m_ack[k] + 1;
                m_pend[k] = 0;
            end else begin
                m_pend[k] = req;
            end
        end else begin
            if (m_busy[k] == m_ack[k] + 1) begin
                m_shc[k] = c_flg; m_shz[k] = z_flg; m_ie[k] = 0;
            end
            m_pend[k] = req;
            m_busy[k] = m_busy[k] - 1;
        end
    endtask

    initial begin
        rst = 1'b1; exec_stb = 1'b0; flg_op = 3'd0; intr = 1'b0;
        c_alu = 1'b0; z_alu = 1'b0; c_flg = 1'b0; z_flg = 1'b0;
        repeat (2) @(posedge clk);

        //  w  rst exe op  int ca za cf zf  expected
        add(0, 1, 1, 3'd2, 0, 1, 1, 0, 0, 9'b000011000); // strobes masked in reset
        add(0, 0, 1, 3'd2, 0, 1, 0, 0, 0, 9'b001110000); // LD_CZ
        add(0, 0, 1, 3'd5, 0, 0, 0, 0, 0, 9'b000000000); // SEI
        add(0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 9'b000000100); // INTR pulse
        add(0, 0, 1, 3'd0, 0, 0, 0, 1, 1, 9'b000000100); // NONE -> entry
        add(0, 0, 0, 3'd0, 0, 1, 1, 1, 1, 9'b010110101); // SAVE, shadow 1/1
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000011); // ACK x1
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000000);
        add(0, 0, 1, 3'd7, 1, 0, 0, 0, 0, 9'b001111000); // RETIE with INTR high
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 1, 9'b010100101); // immediate SAVE, shadow 0/1
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000011);
        add(0, 0, 1, 3'd1, 0, 1, 1, 0, 0, 9'b001011000); // LD_C
        add(0, 0, 1, 3'd3, 0, 0, 0, 0, 0, 9'b100000000); // SET_C
        add(0, 0, 1, 3'd4, 0, 0, 0, 0, 0, 9'b010000000); // CLR_C
        add(0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 9'b000000000); // INTR while IE=0
        for (int i = 0; i < 3; i++)
            add(0, 0, 1, 3'd0, 0, 0, 0, 0, 0, 9'b000000000); // stays pending
        add(0, 0, 1, 3'd6, 0, 0, 0, 0, 0, 9'b000000000); // CLI
        add(0, 0, 1, 3'd5, 0, 0, 0, 0, 0, 9'b000000000); // SEI -> entry from pend
        add(0, 0, 0, 3'd0, 0, 0, 1, 1, 0, 9'b010100101); // SAVE, shadow 1/0
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000011);
        add(0, 0, 1, 3'd5, 0, 0, 0, 0, 0, 9'b000000000); // SEI
        add(0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 9'b000000100); // INTR
        add(0, 0, 1, 3'd6, 0, 0, 0, 0, 0, 9'b000000100); // CLI blocks same cycle
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000000);
        add(0, 0, 1, 3'd7, 0, 0, 0, 0, 0, 9'b001110000); // RETIE restores 1/0 -> entry
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 9'b010100101);
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000011);
        add(0, 0, 1, 3'd5, 0, 0, 0, 0, 0, 9'b000000000);
        add(0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 9'b000000100);
        add(0, 0, 1, 3'd0, 0, 0, 0, 0, 0, 9'b000000100); // entry
        add(0, 0, 0, 3'd0, 0, 0, 0, 1, 1, 9'b010100101); // SAVE, shadow 1/1
        add(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000011); // RST during ACK
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000000); // back in RUN, IE=0
        add(0, 0, 1, 3'd7, 0, 1, 1, 0, 0, 9'b001100000); // shadow cleared by reset
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000100);
        add(0, 0, 1, 3'd6, 0, 0, 0, 0, 0, 9'b000000100);
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000000);
        // ACK_CYCLES=3, CLR_ON_INT=0 instance
        add(2, 1, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000000);
        add(1, 1, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000000);
        add(1, 0, 1, 3'd5, 0, 0, 0, 0, 0, 9'b000000000);
        add(1, 0, 0, 3'd0, 1, 0, 0, 0, 0, 9'b000000100);
        add(1, 0, 1, 3'd0, 0, 0, 0, 0, 0, 9'b000000100); // entry
        add(1, 0, 1, 3'd2, 0, 1, 1, 1, 0, 9'b000011101); // SAVE: no strobes, EXEC ignored
        for (int i = 0; i < 3; i++)
            add(1, 0, 1, 3'd3, 0, 0, 0, 0, 0, 9'b000000011); // 3 ACK cycles, EXEC ignored
        add(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000000);
        add(1, 0, 1, 3'd7, 0, 0, 0, 0, 0, 9'b001110000); // shadow 1/0
        add(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 9'b000000100);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            rst = tbl[i].rst; exec_stb = tbl[i].exec_stb; flg_op = tbl[i].op; intr = tbl[i].intr;
            c_alu = tbl[i].ca; z_alu = tbl[i].za; c_flg = tbl[i].cf; z_flg = tbl[i].zf;
            @(negedge clk);
            if (tbl[i].which == 0) check("vec_a", i, outs(0), tbl[i].exp);
            else if (tbl[i].which == 1) check("vec_b", i, outs(1), tbl[i].exp);
        end

        // randomized phase: reset both instances and models together, then compare every cycle
        @(posedge clk); #1;
        rst = 1'b1; exec_stb = 1'b0; intr = 1'b0;
        @(negedge clk);
        model_step(0); model_step(1);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst      = ($urandom_range(0, 99) == 0);
            exec_stb = $urandom_range(0, 1);
            flg_op   = 3'($urandom_range(0, 7));
            intr     = ($urandom_range(0, 7) == 0);
            c_alu    = $urandom_range(0, 1);
            z_alu    = $urandom_range(0, 1);
            c_flg    = $urandom_range(0, 1);
            z_flg    = $urandom_range(0, 1);
            @(negedge clk);
            check("rand_a", i, outs(0), model_out(0));
            check("rand_b", i, outs(1), model_out(1));
            model_step(0); model_step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
